debug_frame_controller: RTL and testbench
=========================================

Name: debug_frame_controller

Overview:
Parametrised successor to the pipeline debug unit. It accepts single-byte commands from the UART RX FIFO and runs the datapath in continuous, single-step or breakpoint mode. At each stop it latches a snapshot of the pipeline registers and streams it to the UART TX FIFO as a framed packet: header, payload, then an XOR checksum. It sits between the UART FIFOs and the pipelined datapath's enable and reset inputs.

Parameters:
SNAP_BYTES, 96, number of payload bytes per frame (1..255)
PC_WIDTH, 8, width of fetch PC and breakpoint register
HDR_BYTE, 8'hA5, frame header byte

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
end_of_program  in  1  datapath reached end of program
pc  in  PC_WIDTH  current fetch-stage PC
snapshot  in  8*SNAP_BYTES  flat pipeline-register bus; byte i = snapshot[8i+7:8i]
rx_data  in  8  RX FIFO head (first-word-fall-through)
rx_empty  in  1  RX FIFO empty
rx_read  out  1  pop RX FIFO head this cycle
tx_full  in  1  TX FIFO full
tx_data  out  8  byte to TX FIFO
tx_write  out  1  push tx_data this cycle
pipe_enable  out  1  datapath clock enable
pipe_reset  out  1  datapath synchronous reset
bp_valid  out  1  breakpoint armed
state_leds  out  5  one-hot {SEND,BP_ARG,STEP,RUN,IDLE}

Behaviour:
- Reset values: state=IDLE, pipe_reset=1, pipe_enable=0, rx_read=0, tx_write=0, tx_data=0, bp_valid=0, bp_addr=0, byte counter=0, checksum=0, state_leds=5'b00001. All outputs are registered.
- RX handshake: a byte is consumed only when rx_empty=0. The consuming state samples rx_data and drives rx_read=1 for exactly that cycle. At most one pop per cycle. Only one command is decoded per cycle.
- IDLE: pipe_reset=1, pipe_enable=0. Commands:
  - 'c'(0x63) -> RUN
  - 's'(0x73) -> STEP
  - 'b'(0x62) -> BP_ARG
  - 'x'(0x78) -> bp_valid=0
  - Any other byte is popped and ignored.
- BP_ARG: the next popped byte becomes bp_addr[PC_WIDTH-1:0] (zero-extended if PC_WIDTH>8), bp_valid=1, then -> IDLE. No pipe activity.
- RUN: pipe_reset=0, pipe_enable=1.
  - end_of_program=1 -> SEND with return target IDLE.
  - Else if bp_valid and pc==bp_addr -> SEND with return target STEP.
  - end_of_program has priority over the breakpoint.
  - pipe_enable drops in the same cycle the stop is detected (registered next-state decode), so the pipeline advances no further.
  - 'r'(0x72) -> IDLE immediately, no frame sent.
- STEP: pipe_reset=0, pipe_enable=0.
  - 'n'(0x6E) -> pipe_enable=1 for exactly one cycle, then SEND with return target STEP, or IDLE if end_of_program is sampled high after the step.
  - 'r' -> IDLE.
  - Other bytes are popped and ignored.
- SEND entry: the full snapshot bus is latched into an internal buffer on the entry cycle, so the frame is coherent even if inputs change.
- Frame order: HDR_BYTE, payload bytes 0..SNAP_BYTES-1, checksum. Checksum = XOR of payload bytes only. Total SNAP_BYTES+2 bytes.
- TX handshake: tx_write=1 only in cycles where tx_full=0. The counter advances only on an accepted write. If tx_full=1, the byte is held and tx_write=0 (no drops, no duplicates). Back-to-back bytes go out one per cycle when the FIFO has room.
- After the checksum is accepted -> return target. No RX bytes are popped during SEND.
- pipe_enable=0 throughout SEND. pipe_reset=0, except a return to IDLE asserts it the following cycle.
- Counter is 8 bits wide and wraps to 0 at frame end. It never reaches SNAP_BYTES+2.
- reset mid-frame: the frame is abandoned; no further tx_write until a new stop.
- Unknown state encoding -> IDLE.

Test Plan:
- Reset, then push 'c'; end_of_program rises after 10 cycles, tx_full=0 -> exactly 98 tx_write pulses: 0xA5, 96 snapshot bytes in index order, XOR checksum. Then state IDLE and pipe_reset=1.
- 's', then 'n' three times -> pipe_enable high exactly 1 cycle per 'n'; three frames sent; state STEP after each.
- 'b', 0x10, 'c'; pc counts 0,4,8,0x0C,0x10 -> pipe_enable low from the pc==0x10 cycle; one frame sent; state STEP. Then 'x' in IDLE -> bp_valid=0.
- During SEND, hold tx_full=1 for 20 cycles at byte 40 -> no tx_write while full; byte 40 is sent once after release; checksum correct.
- Snapshot bus changes every cycle during SEND -> payload equals the value latched at SEND entry.
- Assert reset at byte 50 of a frame -> all outputs return to reset values asynchronously; no further tx_write; 'c' works afterwards.

Source files
------------

// File: rtl/debug_frame_controller_if.sv
// UART FIFO side of the debug frame controller: RX FWFT head/pop and TX push/full.
// master = controller, slave = FIFO pair.
interface debug_frame_controller_if;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_read;
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_write;

    modport master (
        input  rx_data, rx_empty, tx_full,
        output rx_read, tx_data, tx_write
    );

    modport slave (
        output rx_data, rx_empty, tx_full,
        input  rx_read, tx_data, tx_write
    );
endinterface

// File: rtl/debug_frame_controller.sv
// Debug controller: UART byte commands drive run/step/breakpoint; each stop streams HDR, snapshot, XOR.
// All outputs registered from next-state decode; TX stalls on tx_full, RX pops at most every other cycle.
module debug_frame_controller #(
    parameter int         SNAP_BYTES = 96,
    parameter int         PC_WIDTH   = 8,
    parameter logic [7:0] HDR_BYTE   = 8'hA5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    end_of_program,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [8*SNAP_BYTES-1:0] snapshot,
    debug_frame_controller_if.master uart,
    output logic                    pipe_enable,
    output logic                    pipe_reset,
    output logic                    bp_valid,
    output logic [4:0]              state_leds
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RUN       = 3'd1;
    localparam logic [2:0] S_STEP      = 3'd2;
    localparam logic [2:0] S_BP_ARG    = 3'd3;
    localparam logic [2:0] S_SEND      = 3'd4;
    localparam logic [2:0] S_STEP_GO   = 3'd5;
    localparam logic [2:0] S_STEP_WAIT = 3'd6;

    localparam logic [7:0] CMD_C = 8'h63;
    localparam logic [7:0] CMD_S = 8'h73;
    localparam logic [7:0] CMD_B = 8'h62;
    localparam logic [7:0] CMD_X = 8'h78;
    localparam logic [7:0] CMD_R = 8'h72;
    localparam logic [7:0] CMD_N = 8'h6E;
    localparam logic [7:0] LAST_PAY = 8'(SNAP_BYTES);

    logic [2:0]              state, nxt, ret, ret_nxt;
    logic [PC_WIDTH-1:0]     bp_addr;
    logic [8*SNAP_BYTES-1:0] snap_buf;
    logic [7:0]              cnt, chk, tx_data_q;
    logic                    chk_phase, rx_read_q, tx_write_q;
    logic                    can_pop, pop, bp_set, bp_clr, latch, send;

    assign uart.rx_read  = rx_read_q;
    assign uart.tx_data  = tx_data_q;
    assign uart.tx_write = tx_write_q;

    // The FIFO head only moves after the registered pop, so skip the cycle it is still stale.
    assign can_pop = !uart.rx_empty && !rx_read_q;

    function automatic logic [4:0] leds_of(input logic [2:0] s);
        case (s)
            S_RUN:                          leds_of = 5'b00010;
            S_STEP, S_STEP_GO, S_STEP_WAIT: leds_of = 5'b00100;
            S_BP_ARG:                       leds_of = 5'b01000;
            S_SEND:                         leds_of = 5'b10000;
            default:                        leds_of = 5'b00001;
        endcase
    endfunction

    always_comb begin
        nxt     = state;
        ret_nxt = ret;
        pop     = 1'b0;
        bp_set  = 1'b0;
        bp_clr  = 1'b0;
        latch   = 1'b0;
        send    = 1'b0;
        case (state)
            S_IDLE: begin
                if (can_pop) begin
                    pop = 1'b1;
                    case (uart.rx_data)
                        CMD_C:   nxt = S_RUN;
                        CMD_S:   nxt = S_STEP;
                        CMD_B:   nxt = S_BP_ARG;
                        CMD_X:   bp_clr = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_BP_ARG: begin
                if (can_pop) begin
                    pop    = 1'b1;
                    bp_set = 1'b1;
                    nxt    = S_IDLE;
                end
            end
            S_RUN: begin
                if (end_of_program) begin
                    nxt     = S_SEND;
                    ret_nxt = S_IDLE;
                    latch   = 1'b1;
                end else if (bp_valid && pc == bp_addr) begin
                    nxt     = S_SEND;
                    ret_nxt = S_STEP;
                    latch   = 1'b1;
                end else if (can_pop) begin
                    pop = 1'b1;
                    if (uart.rx_data == CMD_R) nxt = S_IDLE;
                end
            end
            S_STEP: begin
                if (can_pop) begin
                    pop = 1'b1;
                    if (uart.rx_data == CMD_N)      nxt = S_STEP_GO;
                    else if (uart.rx_data == CMD_R) nxt = S_IDLE;
                end
            end
            S_STEP_GO: nxt = S_STEP_WAIT;
            // One cycle after the enable pulse, so end_of_program reflects the completed step.
            S_STEP_WAIT: begin
                nxt     = S_SEND;
                latch   = 1'b1;
                ret_nxt = end_of_program ? S_IDLE : S_STEP;
            end
            S_SEND: begin
                if (!uart.tx_full) begin
                    send = 1'b1;
                    if (chk_phase) nxt = ret;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ret         <= S_IDLE;
            pipe_reset  <= 1'b1;
            pipe_enable <= 1'b0;
            rx_read_q   <= 1'b0;
            tx_write_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            bp_valid    <= 1'b0;
            bp_addr     <= '0;
            cnt         <= 8'h00;
            chk         <= 8'h00;
            chk_phase   <= 1'b0;
            snap_buf    <= '0;
            state_leds  <= 5'b00001;
        end else begin
            state       <= nxt;
            rx_read_q   <= pop;
            tx_write_q  <= send;
            pipe_reset  <= (nxt == S_IDLE) || (nxt == S_BP_ARG);
            pipe_enable <= (nxt == S_RUN) || (nxt == S_STEP_GO);
            state_leds  <= leds_of(nxt);

            if (bp_set) begin
                bp_addr  <= PC_WIDTH'(uart.rx_data);
                bp_valid <= 1'b1;
            end else if (bp_clr) begin
                bp_valid <= 1'b0;
            end

            if (latch) begin
                snap_buf  <= snapshot;
                ret       <= ret_nxt;
                cnt       <= 8'h00;
                chk       <= 8'h00;
                chk_phase <= 1'b0;
            end else if (send) begin
                // Payload drains from the low byte of a shifting buffer; cnt==0 marks the header.
                if (chk_phase) begin
                    tx_data_q <= chk;
                    chk       <= 8'h00;
                    chk_phase <= 1'b0;
                    cnt       <= 8'h00;
                end else if (cnt == 8'h00) begin
                    tx_data_q <= HDR_BYTE;
                    cnt       <= 8'h01;
                end else begin
                    tx_data_q <= snap_buf[7:0];
                    snap_buf  <= snap_buf >> 8;
                    chk       <= chk ^ snap_buf[7:0];
                    if (cnt == LAST_PAY) begin
                        cnt       <= 8'h00;
                        chk_phase <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debug_frame_controller.sv
// Self-checking bench for debug_frame_controller with FIFO and datapath models.
module tb_debug_frame_controller;
    localparam int NB    = 96;
    localparam int FRAME = NB + 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            end_of_program;
    logic [7:0]      pc = 8'h00;
    logic [NB*8-1:0] snapshot;
    logic            pipe_enable, pipe_reset, bp_valid;
    logic [4:0]      state_leds;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]      rx_mem [256];
    logic [7:0]      rx_wr = 8'h00;
    logic [7:0]      rx_rd = 8'h00;
    logic [7:0]      tx_mem [4096];
    logic [11:0]     tx_cnt = 12'h000;
    int              pe_total = 0;
    int              wr_full_total = 0;
    logic            full_at_edge = 1'b0;
    logic            prev_send = 1'b0;
    logic [NB*8-1:0] snap_at_edge, latched_snap;

    always #5 clock = ~clock;

    debug_frame_controller_if u_if ();

    debug_frame_controller #(.SNAP_BYTES(NB), .PC_WIDTH(8), .HDR_BYTE(8'hA5)) dut (
        .clock          (clock),
        .reset          (reset),
        .end_of_program (end_of_program),
        .pc             (pc),
        .snapshot       (snapshot),
        .uart           (u_if),
        .pipe_enable    (pipe_enable),
        .pipe_reset     (pipe_reset),
        .bp_valid       (bp_valid),
        .state_leds     (state_leds)
    );

    // Datapath stand-in: pc advances by 4 on every enabled edge, cleared by pipe_reset.
    always @(posedge clock) begin
        if (pipe_reset === 1'b1)       pc <= 8'h00;
        else if (pipe_enable === 1'b1) pc <= pc + 8'd4;
    end

    always @(posedge clock) begin
        if (u_if.rx_read === 1'b1 && rx_rd != rx_wr) rx_rd <= rx_rd + 8'd1;
        full_at_edge <= u_if.tx_full;
        snap_at_edge <= snapshot;
    end

    always @(negedge clock) begin
        u_if.rx_empty = (rx_rd == rx_wr);
        u_if.rx_data  = rx_mem[rx_rd];
        if (u_if.tx_write === 1'b1) begin
            tx_mem[tx_cnt] = u_if.tx_data;
            tx_cnt = tx_cnt + 12'd1;
            if (full_at_edge) wr_full_total++;
        end
        if (pipe_enable === 1'b1) pe_total++;
        if (state_leds[4] === 1'b1 && !prev_send) latched_snap = snap_at_edge;
        prev_send = (state_leds[4] === 1'b1);
    end

    function automatic logic [7:0] frame_byte(input logic [NB*8-1:0] s, input int i);
        logic [7:0] x;
        x = 8'h00;
        if (i == 0) return 8'hA5;
        if (i <= NB) return s[8*(i-1) +: 8];
        for (int k = 0; k < NB; k++) x ^= s[8*k +: 8];
        return x;
    endfunction

    function automatic int frame_errs(input logic [11:0] base, input logic [NB*8-1:0] s);
        int e;
        e = 0;
        for (int i = 0; i < FRAME; i++)
            if (tx_mem[base + 12'(i)] !== frame_byte(s, i)) e++;
        return e;
    endfunction

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 8'd1;
    endtask

    task automatic rand_snap();
        for (int i = 0; i < NB; i++) snapshot[8*i +: 8] = 8'($urandom);
    endtask

    task automatic wait_leds(input int bit_i, input logic val, input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (state_leds[bit_i] === val) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic start_frame(input int run_cycles, output logic ok);
        logic ok1, ok2;
        push_cmd(8'h63);
        wait_leds(1, 1'b1, 20, ok1);
        repeat (run_cycles) tick();
        end_of_program = 1'b1;
        wait_leds(4, 1'b1, 20, ok2);
        end_of_program = 1'b0;
        ok = ok1 && ok2;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        end_of_program = 1'b0;
        u_if.tx_full = 1'b0;
        rand_snap();
        repeat (3) tick();
        n_checks++;
        if ({pipe_reset, pipe_enable, u_if.rx_read, u_if.tx_write, u_if.tx_data, bp_valid, state_leds}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00001}) begin
            n_fail++;
            $display("FAIL reset_outputs: got pr=%b pe=%b rd=%b wr=%b d=%h bp=%b leds=%b expected 1 0 0 0 00 0 00001",
                     pipe_reset, pipe_enable, u_if.rx_read, u_if.tx_write, u_if.tx_data, bp_valid, state_leds);
        end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (state_leds !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_idle_after_release: got %b expected 00001", state_leds);
        end
    endtask

    task automatic test_continuous();
        logic ok, ok2;
        logic [11:0] base;
        base = tx_cnt;
        rand_snap();
        start_frame(10, ok);
        wait_leds(4, 1'b0, 300, ok2);
        repeat (3) tick();
        n_checks++;
        if ((ok && ok2) !== 1'b1) begin
            n_fail++;
            $display("FAIL cont_timeout: got ok=%b expected 1", ok && ok2);
        end
        n_checks++;
        if (tx_cnt - base !== 12'(FRAME)) begin
            n_fail++;
            $display("FAIL cont_byte_count: got %0d expected %0d", tx_cnt - base, FRAME);
        end
        n_checks++;
        if (frame_errs(base, snapshot) !== 0) begin
            n_fail++;
            $display("FAIL cont_frame_bytes: got %0d bad bytes expected 0", frame_errs(base, snapshot));
        end
        n_checks++;
        if ({state_leds, pipe_reset, pipe_enable} !== {5'b00001, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL cont_return_idle: got leds=%b pr=%b pe=%b expected 00001 1 0", state_leds, pipe_reset, pipe_enable);
        end
    endtask

    task automatic test_single_step();
        logic ok, ok2;
        logic [11:0] base;
        int pe0;
        push_cmd(8'h73);
        wait_leds(2, 1'b1, 20, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL step_enter: got leds=%b expected 00100", state_leds);
        end
        for (int it = 0; it < 3; it++) begin
            rand_snap();
            base = tx_cnt;
            pe0 = pe_total;
            push_cmd(8'h6E);
            wait_leds(4, 1'b1, 20, ok);
            wait_leds(4, 1'b0, 300, ok2);
            repeat (3) tick();
            n_checks++;
            if (pe_total - pe0 !== 1) begin
                n_fail++;
                $display("FAIL step%0d_enable_cycles: got %0d expected 1", it, pe_total - pe0);
            end
            n_checks++;
            if ((ok && ok2) !== 1'b1 || tx_cnt - base !== 12'(FRAME)) begin
                n_fail++;
                $display("FAIL step%0d_byte_count: got %0d expected %0d", it, tx_cnt - base, FRAME);
            end
            n_checks++;
            if (frame_errs(base, snapshot) !== 0) begin
                n_fail++;
                $display("FAIL step%0d_frame_bytes: got %0d bad bytes expected 0", it, frame_errs(base, snapshot));
            end
            n_checks++;
            if (state_leds !== 5'b00100) begin
                n_fail++;
                $display("FAIL step%0d_return_step: got %b expected 00100", it, state_leds);
            end
        end
        push_cmd(8'h72);
        repeat (4) tick();
        n_checks++;
        if (state_leds !== 5'b00001) begin
            n_fail++;
            $display("FAIL step_r_to_idle: got %b expected 00001", state_leds);
        end
    endtask

    task automatic test_breakpoint();
        logic ok, found;
        logic [11:0] base;
        rand_snap();
        push_cmd(8'h62);
        push_cmd(8'h10);
        repeat (8) tick();
        n_checks++;
        if ({bp_valid, state_leds} !== {1'b1, 5'b00001}) begin
            n_fail++;
            $display("FAIL bp_arm: got bp=%b leds=%b expected 1 00001", bp_valid, state_leds);
        end
        base = tx_cnt;
        push_cmd(8'h63);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (pc === 8'h10) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        tick();
        n_checks++;
        if ({found, pipe_enable, state_leds} !== {1'b1, 1'b0, 5'b10000}) begin
            n_fail++;
            $display("FAIL bp_stop: got found=%b pe=%b leds=%b expected 1 0 10000", found, pipe_enable, state_leds);
        end
        wait_leds(4, 1'b0, 300, ok);
        repeat (3) tick();
        n_checks++;
        if (ok !== 1'b1 || tx_cnt - base !== 12'(FRAME) || frame_errs(base, snapshot) !== 0) begin
            n_fail++;
            $display("FAIL bp_frame: got count=%0d bad=%0d expected %0d 0", tx_cnt - base, frame_errs(base, snapshot), FRAME);
        end
        n_checks++;
        if (state_leds !== 5'b00100) begin
            n_fail++;
            $display("FAIL bp_return_step: got %b expected 00100", state_leds);
        end
        push_cmd(8'h72);
        push_cmd(8'h78);
        repeat (8) tick();
        n_checks++;
        if ({bp_valid, state_leds} !== {1'b0, 5'b00001}) begin
            n_fail++;
            $display("FAIL bp_clear: got bp=%b leds=%b expected 0 00001", bp_valid, state_leds);
        end
    endtask

    task automatic test_backpressure();
        logic ok, ok2, hit;
        logic [11:0] base, held;
        int wf0;
        base = tx_cnt;
        wf0 = wr_full_total;
        rand_snap();
        start_frame(3 + int'($urandom_range(0, 5)), ok);
        hit = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (tx_cnt - base == 12'd40) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        u_if.tx_full = 1'b1;
        held = tx_cnt;
        repeat (20) tick();
        n_checks++;
        if ({hit, tx_cnt} !== {1'b1, held}) begin
            n_fail++;
            $display("FAIL bp_stall_hold: got hit=%b count=%0d expected 1 %0d", hit, tx_cnt, held);
        end
        u_if.tx_full = 1'b0;
        wait_leds(4, 1'b0, 300, ok2);
        repeat (3) tick();
        n_checks++;
        if (wr_full_total - wf0 !== 0) begin
            n_fail++;
            $display("FAIL full_write: got %0d writes while full expected 0", wr_full_total - wf0);
        end
        n_checks++;
        if ((ok && ok2) !== 1'b1 || tx_cnt - base !== 12'(FRAME)) begin
            n_fail++;
            $display("FAIL full_byte_count: got %0d expected %0d", tx_cnt - base, FRAME);
        end
        n_checks++;
        if (frame_errs(base, snapshot) !== 0) begin
            n_fail++;
            $display("FAIL full_frame_bytes: got %0d bad bytes expected 0", frame_errs(base, snapshot));
        end
    endtask

    task automatic test_snapshot_change();
        logic seen, done;
        logic [11:0] base;
        base = tx_cnt;
        seen = 1'b0;
        done = 1'b0;
        push_cmd(8'h63);
        for (int i = 0; i < 400 && !done; i++) begin
            rand_snap();
            if (i == 8) end_of_program = 1'b1;
            if (state_leds[4] === 1'b1) begin
                end_of_program = 1'b0;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
            end
            tick();
        end
        repeat (3) tick();
        n_checks++;
        if (done !== 1'b1 || tx_cnt - base !== 12'(FRAME)) begin
            n_fail++;
            $display("FAIL snapchg_byte_count: got done=%b count=%0d expected 1 %0d", done, tx_cnt - base, FRAME);
        end
        n_checks++;
        if (frame_errs(base, latched_snap) !== 0) begin
            n_fail++;
            $display("FAIL snapchg_coherent: got %0d bad bytes expected 0", frame_errs(base, latched_snap));
        end
    endtask

    task automatic test_reset_midframe();
        logic ok, ok2, hit;
        logic [11:0] base, held;
        base = tx_cnt;
        rand_snap();
        start_frame(4, ok);
        hit = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (tx_cnt - base == 12'd50) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({hit, pipe_reset, pipe_enable, u_if.rx_read, u_if.tx_write, u_if.tx_data, bp_valid, state_leds}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 5'b00001}) begin
            n_fail++;
            $display("FAIL midreset_outputs: got hit=%b pr=%b pe=%b rd=%b wr=%b d=%h bp=%b leds=%b expected 1 1 0 0 0 00 0 00001",
                     hit, pipe_reset, pipe_enable, u_if.rx_read, u_if.tx_write, u_if.tx_data, bp_valid, state_leds);
        end
        repeat (3) tick();
        reset = 1'b0;
        held = tx_cnt;
        repeat (20) tick();
        n_checks++;
        if (tx_cnt !== held) begin
            n_fail++;
            $display("FAIL midreset_no_tx: got %0d bytes expected %0d", tx_cnt, held);
        end
        base = tx_cnt;
        rand_snap();
        start_frame(5, ok);
        wait_leds(4, 1'b0, 300, ok2);
        repeat (3) tick();
        n_checks++;
        if ((ok && ok2) !== 1'b1 || tx_cnt - base !== 12'(FRAME) || frame_errs(base, snapshot) !== 0) begin
            n_fail++;
            $display("FAIL midreset_recover: got count=%0d bad=%0d expected %0d 0", tx_cnt - base, frame_errs(base, snapshot), FRAME);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_continuous();
        test_single_step();
        test_breakpoint();
        test_backpressure();
        test_snapshot_change();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
